layer_sequencer: RTL and testbench

Hardware layer sequencer that drives the accelerator core through a programmable list of convolution layers. It replaces bench-side per-layer sequencing with synthesizable control. It sits between the host/config bus and the PE-array top level. It holds one descriptor per layer, resets the core, then issues layers in index order, skipping masked layers. Each layer is handshaked with the core's layer-done signal, and an optional single-step mode pauses between layers.

---
 rtl/layer_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: resets the core, then launches each unmasked layer descriptor in index order.
// Build macro LAYER_SEQ_PERF_EN adds the per-layer RUN-cycle counter output layer_cycles.
module layer_sequencer #(
  parameter int NUM_LAYERS = 5,
  parameter int CFG_W      = 32,
  parameter int RST_CYCLES = 2,
  parameter int GAP_CYCLES = 1,
  parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  core_clk,
  input  logic                  core_rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_mask,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [CFG_W-1:0]      cfg_wdata,
  output logic                  core_soft_rst,
  output logic                  layer_start,
  output logic [IDX_W-1:0]      layer_idx,
  output logic [CFG_W-1:0]      layer_cfg,
  input  logic                  layer_done,
  output logic                  busy,
  output logic                  done
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]           layer_cycles
`endif
);

  localparam int CNT_MAX = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RST,
    GAP,
    HOLD,
    ISSUE,
    RUN,
    FIN
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [NUM_LAYERS-1:0] mask_q;
  logic                  cur_valid;
  logic [IDX_W-1:0]      cur_idx;
  logic [CFG_W-1:0]      table_q [NUM_LAYERS];
  logic                  next_found;
  logic [IDX_W-1:0]      next_idx;
  logic                  issue_entry;
  logic                  seq_accept;

  // Lowest enabled layer above the one last issued; any enabled layer before the first issue.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (mask_q[i] && (!cur_valid || (IDX_W'(i) > cur_idx))) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RST;
          cnt_d   = '0;
        end
      end
      RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!next_found) begin
            state_d = FIN;
          end else if (step_mode && cur_valid) begin
            state_d = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (step) state_d = ISSUE;
      end
      ISSUE: state_d = RUN;
      RUN: begin
        if (layer_done) state_d = GAP;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition, including a start seen in IDLE.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // ISSUE always exits after one cycle, so a next state of ISSUE is always an entry.
  assign issue_entry = (state_d == ISSUE);
  assign seq_accept  = (state_q == IDLE) && (state_d == RST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      // NOTE: the descriptor table is a small register file, so it is cleared by reset like any flop.
      for (int i = 0; i < NUM_LAYERS; i++) table_q[i] <= '0;
    end else if (cfg_we && (int'(cfg_addr) < NUM_LAYERS)) begin
      table_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      mask_q    <= '0;
      cur_valid <= 1'b0;
      cur_idx   <= '0;
    end else if (seq_accept) begin
      mask_q    <= layer_mask;
      cur_valid <= 1'b0;
    end else if (issue_entry) begin
      cur_idx   <= next_idx;
      cur_valid <= 1'b1;
    end
  end

  // The issued descriptor is captured at ISSUE entry, so later table writes wait for the next issue.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      layer_idx <= '0;
      layer_cfg <= '0;
    end else if (issue_entry) begin
      layer_idx <= next_idx;
      layer_cfg <= table_q[next_idx];
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      core_soft_rst <= 1'b0;
      layer_start   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      core_soft_rst <= (state_d == RST);
      layer_start   <= (state_d == ISSUE);
      busy          <= (state_d != IDLE);
      done          <= (state_d == FIN);
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      layer_cycles <= '0;
    end else if (issue_entry) begin
      layer_cycles <= '0;
    end else if ((state_q == RUN) && (layer_cycles != 32'hFFFF_FFFF)) begin
      layer_cycles <= layer_cycles + 32'd1;
    end
  end
`endif

  a_start_busy : assert property (@(posedge core_clk) disable iff (!core_rst_n)
    layer_start |-> busy);
  a_done_busy : assert property (@(posedge core_clk) disable iff (!core_rst_n)
    done |-> busy);
  a_rst_excl : assert property (@(posedge core_clk) disable iff (!core_rst_n)
    !(layer_start && core_soft_rst));
  a_idx_range : assert property (@(posedge core_clk) disable iff (!core_rst_n)
    int'(layer_idx) < NUM_LAYERS);

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: fixed scenario table, hand-written abort/reset sequences and a randomized
// schedule-based reference model for layer_sequencer.
module tb_layer_sequencer;

  localparam int NL = 5;
  localparam int CW = 32;
  localparam int RC = 2;
  localparam int GC = 1;
  localparam int IW = 3;

  logic          core_clk;
  logic          core_rst_n;
  logic          start;
  logic          abort;
  logic [NL-1:0] layer_mask;
  logic          step_mode;
  logic          step;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          core_soft_rst;
  logic          layer_start;
  logic [IW-1:0] layer_idx;
  logic [CW-1:0] layer_cfg;
  logic          layer_done;
  logic          busy;
  logic          done;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0]   layer_cycles;
`endif

  layer_sequencer #(
    .NUM_LAYERS(NL),
    .CFG_W     (CW),
    .RST_CYCLES(RC),
    .GAP_CYCLES(GC),
    .IDX_W     (IW)
  ) dut (
    .core_clk     (core_clk),
    .core_rst_n   (core_rst_n),
    .start        (start),
    .abort        (abort),
    .layer_mask   (layer_mask),
    .step_mode    (step_mode),
    .step         (step),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .core_soft_rst(core_soft_rst),
    .layer_start  (layer_start),
    .layer_idx    (layer_idx),
    .layer_cfg    (layer_cfg),
    .layer_done   (layer_done),
    .busy         (busy),
    .done         (done)
`ifdef LAYER_SEQ_PERF_EN
    ,
    .layer_cycles (layer_cycles)
`endif
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: descriptor table, last issued descriptor and perf counter.
  logic [CW-1:0] mtbl [NL];
  int            exp_idx;
  logic [CW-1:0] exp_cfg;
  logic [CW-1:0] snap_cfg;
  logic [31:0]   exp_lc;

  // Per-layer schedule of the random run: launch cycle, done edge, step edge (-1 = none).
  int sa [NL];
  int sd [NL];
  int ss [NL];

  typedef struct {
    logic [NL-1:0] mask;
    int            cnt;
    int            first;
    int            fin;
    int            idx;
    logic [CW-1:0] cfg;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] outs_now();
    return {25'b0, core_soft_rst, layer_start, busy, done, layer_idx, layer_cfg};
  endfunction

  function automatic logic [63:0] exp_vec(input bit r, input bit ls, input bit b, input bit d,
                                          input int idx, input logic [CW-1:0] cfg);
    return {25'b0, r, ls, b, d, IW'(idx), cfg};
  endfunction

  function automatic bit in_set(input int arr [NL], input int n);
    for (int k = 0; k < NL; k++) if (arr[k] >= 0 && arr[k] == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_run(input int n);
    for (int k = 0; k < NL; k++) if (sa[k] >= 0 && sa[k] < n && n <= sd[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    start      = 1'b0;
    abort      = 1'b0;
    step       = 1'b0;
    step_mode  = 1'b0;
    layer_done = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    layer_mask = '0;
  endtask

  // One sequence with a core that answers 10 cycles after every layer_start.
  task automatic run_fixed(input logic [NL-1:0] m, output int cnt, output int first,
                           output int fin, output int rstc, output int donec);
    int due;
    due   = -1;
    cnt   = 0;
    first = -1;
    fin   = -1;
    rstc  = 0;
    donec = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge core_clk);
      if (n > 0) begin
        if (core_soft_rst) rstc++;
        if (layer_start) begin
          cnt++;
          if (first < 0) first = n;
          due = n + 10;
        end
        if (done) begin
          donec++;
          fin = n;
        end
      end
      start      = (n == 0);
      layer_mask = m;
      step_mode  = 1'b0;
      layer_done = (n == due);
      if (n > 0 && !busy && fin >= 0) break;
    end
  endtask

  // Randomized run checked cycle by cycle against a schedule computed from the timing rules.
  task automatic run_random(input bit smode);
    logic [NL-1:0] m;
    int            p;
    int            f;
    bit            first;
    bit            e_ls;
    m = NL'($urandom);
    if ($urandom_range(0, 5) == 0) m = '0;
    p     = RC + GC + 1;
    first = 1'b1;
    for (int k = 0; k < NL; k++) begin
      sa[k] = -1;
      sd[k] = -1;
      ss[k] = -1;
      if (m[k]) begin
        if (!first && smode) begin
          ss[k] = p + int'($urandom_range(0, 4));
          sa[k] = ss[k] + 1;
        end else begin
          sa[k] = p;
        end
        sd[k] = sa[k] + int'($urandom_range(1, 6));
        p     = sd[k] + GC + 1;
        first = 1'b0;
      end
    end
    f = p;
    for (int n = 0; n <= f + 2; n++) begin
      @(negedge core_clk);
      for (int k = 0; k < NL; k++) begin
        if (sa[k] == n) begin
          exp_idx = k;
          exp_cfg = snap_cfg;
        end
      end
      e_ls = in_set(sa, n);
      if (e_ls) exp_lc = '0;
      else if (in_run(n - 1) && exp_lc != 32'hFFFF_FFFF) exp_lc = exp_lc + 32'd1;
      check($sformatf("rand m=%b s=%0d cyc%0d", m, smode, n), outs_now(),
            exp_vec((n >= 1 && n <= RC), e_ls, (n >= 1 && n <= f), (n == f), exp_idx, exp_cfg));
`ifdef LAYER_SEQ_PERF_EN
      check($sformatf("rand perf cyc%0d", n), 64'(layer_cycles), 64'(exp_lc));
`endif
      for (int k = 0; k < NL; k++) if (sa[k] == n + 1) snap_cfg = mtbl[k];
      start      = (n == 0) || (n >= 1 && n < f && $urandom_range(0, 7) == 0);
      layer_mask = (n == 0) ? m : NL'($urandom);
      step_mode  = smode;
      step       = in_set(ss, n);
      layer_done = in_set(sd, n) || (!in_run(n) && $urandom_range(0, 3) == 0);
      abort      = 1'b0;
      cfg_we     = ($urandom_range(0, 2) == 0);
      cfg_addr   = IW'($urandom_range(0, 7));
      cfg_wdata  = $urandom;
      if (cfg_we && int'(cfg_addr) < NL) mtbl[cfg_addr] = cfg_wdata;
    end
  endtask

  initial begin
    int cnt;
    int first;
    int fin;
    int rstc;
    int donec;
    int dn;

    vecs[0] = '{5'b11111, 5, 4, 64, 4, 32'hA4};
    vecs[1] = '{5'b00001, 1, 4, 16, 0, 32'hA0};
    vecs[2] = '{5'b10100, 2, 4, 28, 4, 32'hA4};
    vecs[3] = '{5'b00000, 0, -1, 4, 4, 32'hA4};
    vecs[4] = '{5'b01010, 2, 4, 28, 3, 32'hA3};

    idle_inputs();
    core_rst_n = 1'b0;
    for (int i = 0; i < NL; i++) mtbl[i] = '0;
    exp_idx  = 0;
    exp_cfg  = '0;
    snap_cfg = '0;
    exp_lc   = '0;
    repeat (2) @(negedge core_clk);
    check("reset outputs", outs_now(), 64'd0);
`ifdef LAYER_SEQ_PERF_EN
    check("reset perf", 64'(layer_cycles), 64'd0);
`endif
    core_rst_n = 1'b1;

    // Descriptors 0xA0+i, then out-of-range writes that must be dropped.
    for (int i = 0; i < 8; i++) begin
      @(negedge core_clk);
      cfg_we    = 1'b1;
      cfg_addr  = IW'(i);
      cfg_wdata = (i < NL) ? (32'hA0 + 32'(i)) : (32'hDEAD_0000 + 32'(i));
    end
    @(negedge core_clk);
    cfg_we = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_fixed(vecs[v].mask, cnt, first, fin, rstc, donec);
      check($sformatf("vec%0d launches", v), 64'(cnt), 64'(vecs[v].cnt));
      check($sformatf("vec%0d first launch", v), 64'(first), 64'(vecs[v].first));
      check($sformatf("vec%0d done cycle", v), 64'(fin), 64'(vecs[v].fin));
      check($sformatf("vec%0d done pulses", v), 64'(donec), 64'd1);
      check($sformatf("vec%0d soft rst cycles", v), 64'(rstc), 64'(RC));
      check($sformatf("vec%0d idx/cfg", v), {29'b0, layer_idx, layer_cfg},
            {29'b0, IW'(vecs[v].idx), vecs[v].cfg});
    end

    // Abort during RUN of layer 2, with a start in the same cycle and spurious strobes.
    dn = 0;
    for (int n = 0; n <= 45; n++) begin
      @(negedge core_clk);
      if (n > 0 && done) dn++;
      if (n == 16) check("abort l1 launch", {60'b0, layer_start, layer_idx}, {60'b0, 1'b1, 3'd1});
      if (n == 28) check("abort l2 launch", {28'b0, layer_start, layer_idx, layer_cfg},
                         {28'b0, 1'b1, 3'd2, 32'hA2});
      if (n == 33) check("abort outputs low", {60'b0, busy, layer_start, core_soft_rst, done}, 64'd0);
`ifdef LAYER_SEQ_PERF_EN
      if (n == 15) check("perf after done", 64'(layer_cycles), 64'd10);
      if (n == 16) check("perf cleared at issue", 64'(layer_cycles), 64'd0);
`endif
      start      = (n == 0) || (n == 10) || (n == 32);
      layer_mask = 5'b11111;
      layer_done = (n == 14) || (n == 26) || (n == 38);
      abort      = (n == 32);
    end
    idle_inputs();
    check("abort no done", 64'(dn), 64'd0);
    check("abort stays idle", {28'b0, busy, layer_idx, layer_cfg}, {28'b0, 1'b0, 3'd2, 32'hA2});

    // Asynchronous reset in the middle of layer 1.
    for (int n = 0; n <= 20; n++) begin
      @(negedge core_clk);
      start      = (n == 0);
      layer_mask = 5'b11111;
      layer_done = (n == 14);
    end
    check("pre-reset idx", 64'(layer_idx), 64'd1);
    #2 core_rst_n = 1'b0;
    #1 check("async reset outputs", outs_now(), 64'd0);
    idle_inputs();
    @(negedge core_clk);
    core_rst_n = 1'b1;
    for (int i = 0; i < NL; i++) mtbl[i] = '0;
    run_fixed(5'b00001, cnt, first, fin, rstc, donec);
    check("post-reset launches", 64'(cnt), 64'd1);
    check("post-reset done cycle", 64'(fin), 64'd16);
    check("post-reset table cleared", {29'b0, layer_idx, layer_cfg}, 64'd0);
    exp_idx = 0;
    exp_cfg = '0;
    exp_lc  = 32'd10;

    for (int r = 0; r < 12; r++) run_random(r[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
